// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter giving two requesters single-word access to one memory,
// three cycles per transaction (IDLE sample, ACCESS strobe, RESP ack).
module data_mem_arbiter #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // one extra bit so a DEPTH that does not fit in DATA_W still compares correctly
    localparam logic [DATA_W:0] LIMIT = (DATA_W+1)'(DEPTH);

    state_t            state, state_nx;
    logic              last, last_nx;
    logic              win, win_nx;
    logic              we_r, we_nx;
    logic              err_r, err_nx;
    logic [DATA_W-1:0] addr_r, addr_nx;
    logic [DATA_W-1:0] wdata_r, wdata_nx;
    logic [DATA_W-1:0] rdata_r, rdata_nx;
    logic              in_range;
    logic              access;

    assign in_range = {1'b0, addr_r} < LIMIT;
    assign access   = state == ACCESS;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            win     <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            win     <= win_nx;
            we_r    <= we_nx;
            err_r   <= err_nx;
            addr_r  <= addr_nx;
            wdata_r <= wdata_nx;
            rdata_r <= rdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        win_nx   = win;
        we_nx    = we_r;
        err_nx   = err_r;
        addr_nx  = addr_r;
        wdata_nx = wdata_r;
        rdata_nx = rdata_r;
        case (state)
            IDLE: if (req0 || req1) begin
                win_nx   = (req0 && req1) ? ~last : req1;
                we_nx    = win_nx ? we1 : we0;
                addr_nx  = win_nx ? addr1 : addr0;
                wdata_nx = win_nx ? wdata1 : wdata0;
                state_nx = ACCESS;
            end
            ACCESS: begin
                rdata_nx = (in_range && !we_r) ? mem_read_data : '0;
                err_nx   = !in_range;
                state_nx = RESP;
            end
            RESP: begin
                last_nx  = win;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_read       = access && in_range && !we_r;
    assign mem_write      = access && in_range && we_r;
    assign mem_addr       = access ? addr_r : '0;
    assign mem_write_data = mem_write ? wdata_r : '0;

    assign ack0   = state == RESP && !win;
    assign ack1   = state == RESP && win;
    assign rdata0 = ack0 ? rdata_r : '0;
    assign rdata1 = ack1 ? rdata_r : '0;
    assign err0   = ack0 && err_r;
    assign err1   = ack1 && err_r;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed table, multi-cycle corner sequences and a randomized
// two-requester run checked against a transaction-level reference model.
module tb_data_mem_arbiter;
    localparam int DEPTH = 16;

    logic        clk = 0, rst_n = 0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err0, err1, mem_write, mem_read;
    logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;

    int tests = 0, fails = 0;

    logic [31:0] smem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) smem[i] = 32'(5 * (i + 1));
    always @(posedge clk) if (mem_write && mem_addr < DEPTH) smem[mem_addr[3:0]] <= mem_write_data;
    assign mem_read_data = (mem_addr < DEPTH) ? smem[mem_addr[3:0]] : 32'h0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".ack0"}, 32'(ack0), 0);
        chk({name, ".ack1"}, 32'(ack1), 0);
        chk({name, ".rdata0"}, rdata0, 0);
        chk({name, ".rdata1"}, rdata1, 0);
        chk({name, ".err"}, 32'({err0, err1}), 0);
        chk({name, ".strobes"}, 32'({mem_read, mem_write}), 0);
        chk({name, ".mem_addr"}, mem_addr, 0);
        chk({name, ".mem_wdata"}, mem_write_data, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          drop;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    // single transaction from an idle negedge; returns on the idle negedge after the ack
    task automatic do_txn(input vec_t v, input int idx);
        string n;
        bit inr;
        n = $sformatf("vec%0d", idx);
        inr = v.addr < DEPTH;
        drive(v.port, 1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk({n, ".acc_ack"}, 32'({ack0, ack1}), 0);
        chk({n, ".mem_read"}, 32'(mem_read), 32'(inr && !v.we));
        chk({n, ".mem_write"}, 32'(mem_write), 32'(inr && v.we));
        chk({n, ".mem_addr"}, mem_addr, v.addr);
        if (inr && v.we) chk({n, ".mem_wdata"}, mem_write_data, v.wdata);
        if (v.drop) drive(v.port, 0, 0, 0, 0);
        @(negedge clk);
        chk({n, ".ack"}, 32'({ack1, ack0}), v.port ? 2 : 1);
        chk({n, ".rdata"}, v.port ? rdata1 : rdata0, v.exp_rdata);
        chk({n, ".err"}, 32'(v.port ? err1 : err0), 32'(v.exp_err));
        chk({n, ".other_rdata"}, v.port ? rdata0 : rdata1, 0);
        drive(v.port, 0, 0, 0, 0);
        @(negedge clk);
        chk_idle({n, ".after"});
    endtask

    // reference model state for the random run
    typedef struct {
        bit          v;
        bit          port;
        int          acc_cyc;
        int          ack_cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } pend_t;

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(5))
            0: return 32'(DEPTH - 1);
            1: return 32'(DEPTH);
            2: return 32'hFFFF_FFFF;
            3: return $urandom;
            default: return 32'($urandom_range(DEPTH - 1));
        endcase
    endfunction

    initial begin
        vec_t vt[10];
        int ack_port[$];
        int ack_cyc[$];
        logic [31:0] ref_mem [DEPTH];
        pend_t pend;
        bit last, active[2];
        int free;

        vt[0] = '{0, 0, 3,            0,            0, 20,           0};
        vt[1] = '{1, 1, 15,           32'hDEAD_BEEF, 0, 0,           0};
        vt[2] = '{1, 0, 15,           0,            0, 32'hDEAD_BEEF, 0};
        vt[3] = '{0, 0, 16,           0,            0, 0,            1};
        vt[4] = '{1, 0, 32'hFFFF_FFFF, 0,           0, 0,            1};
        vt[5] = '{0, 1, 16,           32'h1234,     0, 0,            1};
        vt[6] = '{0, 0, 0,            0,            1, 5,            0};
        vt[7] = '{1, 1, 7,            32'hA5A5_0F0F, 1, 0,           0};
        vt[8] = '{0, 0, 7,            0,            0, 32'hA5A5_0F0F, 0};
        vt[9] = '{1, 0, 14,           0,            0, 75,           0};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) do_txn(vt[i], i);

        // reset during ACCESS of a write: no ack, strobed write stays, requester 0 wins next tie
        drive(1, 1, 1, 2, 32'h77);
        @(negedge clk);
        chk("abort.mem_write", 32'(mem_write), 1);
        rst_n = 0;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk_idle("abort");
        chk("abort.mem_kept", smem[2], 32'h77);
        rst_n = 1;
        drive(0, 1, 0, 4, 0);
        drive(1, 1, 0, 5, 0);
        @(negedge clk);
        chk("tie.ack_early", 32'({ack0, ack1}), 0);
        @(negedge clk);
        chk("tie.ack", 32'({ack1, ack0}), 1);
        chk("tie.rdata0", rdata0, 25);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);

        // both hold reads of addr 0 from reset: strict alternation, three cycles apart
        do_reset();
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (ack0 && ack1) chk("rr.both_ack", 1, 0);
            if (ack0 || ack1) begin
                ack_port.push_back(ack1 ? 1 : 0);
                ack_cyc.push_back(k);
                chk($sformatf("rr.rdata%0d", ack_port.size()), ack1 ? rdata1 : rdata0, 5);
                if (ack_port.size() == 4) begin
                    drive(0, 0, 0, 0, 0);
                    drive(1, 0, 0, 0, 0);
                end
            end
        end
        chk("rr.count", 32'(ack_port.size()), 4);
        for (int i = 0; i < ack_port.size(); i++) begin
            chk($sformatf("rr.grant%0d", i), 32'(ack_port[i]), 32'(i % 2));
            chk($sformatf("rr.cycle%0d", i), 32'(ack_cyc[i]), 32'(2 + 3 * i));
        end

        // randomized run against the transaction-level model
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = smem[i];
        pend = '{default: 0};
        last = 1;
        free = 0;
        active = '{0, 0};
        for (int c = 0; c < 800; c++) begin
            bit e0, e1, acc, inr, w;
            if (c > 0) @(negedge clk);
            e0  = pend.v && c == pend.ack_cyc && !pend.port;
            e1  = pend.v && c == pend.ack_cyc && pend.port;
            acc = pend.v && c == pend.acc_cyc;
            inr = pend.addr < DEPTH;
            chk("rnd.ack0", 32'(ack0), 32'(e0));
            chk("rnd.ack1", 32'(ack1), 32'(e1));
            chk("rnd.rdata0", rdata0, e0 ? pend.rdata : 0);
            chk("rnd.rdata1", rdata1, e1 ? pend.rdata : 0);
            chk("rnd.err0", 32'(err0), 32'(e0 && pend.err));
            chk("rnd.err1", 32'(err1), 32'(e1 && pend.err));
            chk("rnd.mem_read", 32'(mem_read), 32'(acc && inr && !pend.we));
            chk("rnd.mem_write", 32'(mem_write), 32'(acc && inr && pend.we));
            chk("rnd.mem_addr", mem_addr, acc ? pend.addr : 0);
            if (e0 || e1) begin
                active[pend.port] = 0;
                pend.v = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!active[p]) begin
                    if ($urandom_range(1) == 1) begin
                        active[p] = 1;
                        drive(p[0], 1, $urandom_range(1) == 1, rand_addr(), $urandom);
                    end else drive(p[0], 0, 0, 0, 0);
                end else if (pend.v && pend.port == p[0] && $urandom_range(3) == 0)
                    drive(p[0], 0, 0, 0, 0);
            end
            if (c >= free && (req0 || req1)) begin
                w = (req0 && req1) ? !last : req1;
                pend.v       = 1;
                pend.port    = w;
                pend.acc_cyc = c + 1;
                pend.ack_cyc = c + 2;
                pend.we      = w ? we1 : we0;
                pend.addr    = w ? addr1 : addr0;
                pend.wdata   = w ? wdata1 : wdata0;
                pend.err     = !(pend.addr < DEPTH);
                pend.rdata   = 0;
                if (!pend.err && pend.we) ref_mem[pend.addr[3:0]] = pend.wdata;
                else if (!pend.err) pend.rdata = ref_mem[pend.addr[3:0]];
                last = w;
                free = c + 3;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
